// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- six-line, rising-edge interrupt controller for a MIPS-style CP0.
//
// Each external line is synchronized (2 flops) and edge-detected.  A detected
// edge latches a pending bit, whatever the mask says.  The lowest-index line
// that is both pending and enabled is offered to the CPU as a registered
// request.  The request holds until the CPU acknowledges it.  ERET retires the
// lowest-index in-service handler.
//
// Optional feature macro: INT_CTRL_NEST_EN
//   When it is defined, a pending enabled line of strictly higher priority
//   (lower index) than every active handler may pre-empt it (nested interrupt).
//   When it is undefined, at most one handler is active and no request is
//   raised while a handler runs.
//
// Ports
//   clk         in   1  clock; all state updates on the rising edge
//   rst_n       in   1  asynchronous active-low reset
//   irq         in   6  external interrupt lines (asynchronous to clk)
//   mask_we     in   1  write strobe for the enable mask
//   mask_wdata  in   6  new enable mask (1 = line enabled)
//   ack         in   1  CPU took the interrupt exception this cycle
//   eret        in   1  CPU executed ERET
//   int_req     out  1  registered interrupt request
//   int_cause   out 32  Cause word: IP[15:10] one-hot selected line, else 0
//   pending     out  6  latched pending lines (mask not applied)
//   in_service  out  6  lines whose handlers are active
// -----------------------------------------------------------------------------
module int_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  irq,
  input  logic        mask_we,
  input  logic [5:0]  mask_wdata,
  input  logic        ack,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] int_cause,
  output logic [5:0]  pending,
  output logic [5:0]  in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  sync1_reg, sync2_reg, prev_reg;
  logic [2:0]  warm_reg;
  logic [5:0]  pending_reg, pending_next;
  logic [5:0]  mask_reg;
  logic [5:0]  in_service_reg, in_service_next;
  logic [5:0]  sel_reg, sel_next;
  logic        int_req_reg, int_req_next;
  logic [5:0]  clr;
  logic [5:0]  rise;
  logic [5:0]  cand, cand_low, svc_low;
`ifdef INT_CTRL_NEST_EN
  logic [5:0]  nest_cand;
`endif

  // Edge detection is held off until both sync2 and prev carry samples taken
  // after reset release.  A line that is already high at release therefore
  // does not register as a rising edge.
  assign rise     = sync2_reg & ~prev_reg & {6{warm_reg[2]}};

  // Enabled pending lines and their lowest-index (highest priority) member.
  assign cand     = pending_reg & mask_reg;
  assign cand_low = cand & (~cand + 6'd1);

  // Lowest-index active handler.  ERET retires this handler.
  assign svc_low  = in_service_reg & (~in_service_reg + 6'd1);

`ifdef INT_CTRL_NEST_EN
  // Candidates that outrank every active handler (all bits below svc_low).
  assign nest_cand = cand & (svc_low - 6'd1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      prev_reg       <= '0;
      warm_reg       <= '0;
      state_reg      <= IDLE;
      pending_reg    <= '0;
      mask_reg       <= '0;
      in_service_reg <= '0;
      sel_reg        <= '0;
      int_req_reg    <= 1'b0;
    end else begin
      sync1_reg      <= irq;
      sync2_reg      <= sync1_reg;
      prev_reg       <= sync2_reg;
      warm_reg       <= {warm_reg[1:0], 1'b1};
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      sel_reg        <= sel_next;
      int_req_reg    <= int_req_next;
      if (mask_we)
        mask_reg <= mask_wdata;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    int_req_next    = int_req_reg;
    in_service_next = in_service_reg;
    clr             = '0;

    case (state_reg)
      IDLE: begin
        if (|cand) begin
          state_next   = REQ;
          sel_next     = cand_low;
          int_req_next = 1'b1;
        end
      end

      // The request is committed: it does not track later mask or pending
      // changes.  Only ack moves it on.
      REQ: begin
        if (ack) begin
          clr             = sel_reg;
          in_service_next = in_service_reg | sel_reg;
          state_next      = SERVICE;
          int_req_next    = 1'b0;
          sel_next        = '0;
        end
      end

      SERVICE: begin
        if (eret) begin
          in_service_next = in_service_reg & ~svc_low;
          if (in_service_next == 6'd0)
            state_next = IDLE;
        end
`ifdef INT_CTRL_NEST_EN
        else if (|nest_cand) begin
          state_next   = REQ;
          sel_next     = cand_low;
          int_req_next = 1'b1;
        end
`endif
      end

      default: begin
        state_next   = IDLE;
        sel_next     = '0;
        int_req_next = 1'b0;
      end
    endcase

    // A fresh edge on the line being acknowledged survives the clear.
    pending_next = (pending_reg & ~clr) | rise;
  end

  assign int_req    = int_req_reg;
  // sel_reg is zero outside REQ, so the cause word is zero whenever
  // int_req is low.
  assign int_cause  = {16'd0, sel_reg, 10'd0};
  assign pending    = pending_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- self-checking bench for int_ctrl.
// A behavioural model tracks the sampled-irq history as a queue, the active
// handlers as a list of line numbers, and the committed request as a line
// number.  Every clock step compares all four outputs against this model.
// Directed scenarios come first, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  irq = '0;
  logic        mask_we = 1'b0;
  logic [5:0]  mask_wdata = '0;
  logic        ack = 1'b0;
  logic        eret = 1'b0;
  logic        int_req;
  logic [31:0] int_cause;
  logic [5:0]  pending;
  logic [5:0]  in_service;

  int checks = 0;
  int errors = 0;

`ifdef INT_CTRL_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  int_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eret       (eret),
    .int_req    (int_req),
    .int_cause  (int_cause),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [5:0] m_pend;
  logic [5:0] m_mask;
  int         m_mode;
  int         m_line;
  int         m_svc[$];
  logic [5:0] m_samp[$];   // irq samples taken since reset release

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [5:0] svc_bits();
    logic [5:0] b = '0;
    foreach (m_svc[i]) b[m_svc[i]] = 1'b1;
    return b;
  endfunction

  function automatic int svc_min();
    int m = 6;
    foreach (m_svc[i]) if (m_svc[i] < m) m = m_svc[i];
    return m;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_mask = '0;
    m_mode = M_IDLE;
    m_line = -1;
    m_svc.delete();
    m_samp.delete();
  endtask

  task automatic model_edge(input logic [5:0] i, input logic mw,
                            input logic [5:0] md, input logic a, input logic e);
    logic [5:0] rises = '0;
    int s = m_samp.size();
    int l;
    // A rising edge needs a low and then a high sample, both after release.
    // The second sample must be two clocks old (synchronizer delay).
    if (s >= 3) rises = m_samp[s-2] & ~m_samp[s-3];
    m_samp.push_back(i);
    if (m_samp.size() > 4) void'(m_samp.pop_front());

    case (m_mode)
      M_IDLE: begin
        l = lowest(m_pend & m_mask);
        if (l >= 0) begin
          m_line = l;
          m_mode = M_REQ;
        end
      end
      M_REQ: begin
        if (a) begin
          m_pend[m_line] = 1'b0;
          m_svc.push_back(m_line);
          m_line = -1;
          m_mode = M_SVC;
        end
      end
      default: begin
        if (e) begin
          int mn = svc_min();
          foreach (m_svc[k])
            if (m_svc[k] == mn) begin
              m_svc.delete(k);
              break;
            end
          if (m_svc.size() == 0) m_mode = M_IDLE;
        end else if (NEST) begin
          l = lowest(m_pend & m_mask);
          if (l >= 0 && l < svc_min()) begin
            m_line = l;
            m_mode = M_REQ;
          end
        end
      end
    endcase

    m_pend = m_pend | rises;
    if (mw) m_mask = md;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare just after.
  task automatic step(input logic [5:0] i, input logic mw, input logic [5:0] md,
                      input logic a, input logic e);
    logic [31:0] exp_cause;
    irq = i; mask_we = mw; mask_wdata = md; ack = a; eret = e;
    @(posedge clk);
    model_edge(i, mw, md, a, e);
    #1;
    exp_cause = (m_mode == M_REQ) ? (32'h1 << (10 + m_line)) : 32'h0;
    check("int_req",    {31'd0, int_req},  {31'd0, m_mode == M_REQ});
    check("int_cause",  int_cause,         exp_cause);
    check("pending",    {26'd0, pending},  {26'd0, m_pend});
    check("in_service", {26'd0, in_service}, {26'd0, svc_bits()});
    $display("t=%0t irq=%b mw=%b md=%b ack=%b eret=%b -> req=%b cause=%h pend=%b svc=%b",
             $time, i, mw, md, a, e, int_req, int_cause, pending, in_service);
  endtask

  task automatic idle(input int n);
    repeat (n) step(irq, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    check({tag, "_req"},   {31'd0, int_req}, 32'd0);
    check({tag, "_cause"}, int_cause, 32'd0);
    check({tag, "_pend"},  {26'd0, pending}, 32'd0);
    check({tag, "_svc"},   {26'd0, in_service}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, int_req}, 32'd0);
    check("rst_cause", int_cause, 32'd0);
    check("rst_pend",  {26'd0, pending}, 32'd0);
    check("rst_svc",   {26'd0, in_service}, 32'd0);
    #2 rst_n = 1'b1;

    // Single line latency: pending at k+2, request after k+3.
    step(6'h00, 1'b1, 6'h01, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r030_pend", {26'd0, pending}, 32'h1);
    check("r030_noreq", {31'd0, int_req}, 32'd0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r030_req", {31'd0, int_req}, 32'd1);
    check("r030_cause", int_cause, 32'h0000_0400);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r030_svc", {26'd0, in_service}, 32'h1);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    idle(2);

    // Simultaneous lines 1 and 3: priority, then the second request.
    step(6'h00, 1'b1, 6'h3f, 1'b0, 1'b0);
    step(6'h0a, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r031_cause1", int_cause, 32'h0000_0800);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r031_cause3", int_cause, 32'h0000_2000);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r031_svc", {26'd0, in_service}, 32'h8);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    idle(2);

    // Masked line stays pending; enabling it raises the request next cycle.
    step(6'h00, 1'b1, 6'h00, 1'b0, 1'b0);
    step(6'h04, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r032_pend", {26'd0, pending}, 32'h4);
    idle(3);
    check("r032_noreq", {31'd0, int_req}, 32'd0);
    step(6'h00, 1'b1, 6'h04, 1'b0, 1'b0);
    check("r032_req_early", {31'd0, int_req}, 32'd0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r032_req", {31'd0, int_req}, 32'd1);
    check("r032_cause", int_cause, 32'h0000_1000);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    idle(2);

    // Ack coinciding with a new edge on the same line: pending is kept.
    step(6'h00, 1'b1, 6'h01, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r033_req", {31'd0, int_req}, 32'd1);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r033_svc", {26'd0, in_service}, 32'h1);
    check("r033_pend", {26'd0, pending}, 32'h1);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r033_req2", {31'd0, int_req}, 32'd1);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r033_pend_clr", {26'd0, pending}, 32'h0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    idle(2);

    // Line 4 in service, then line 1 arrives.
    step(6'h00, 1'b1, 6'h3f, 1'b0, 1'b0);
    step(6'h10, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r034_cause4", int_cause, 32'h0000_4000);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r034_svc4", {26'd0, in_service}, 32'h10);
    step(6'h02, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
`ifdef INT_CTRL_NEST_EN
    check("r034_nest_req", {31'd0, int_req}, 32'd1);
    check("r034_nest_cause", int_cause, 32'h0000_0800);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r034_nest_svc", {26'd0, in_service}, 32'h12);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    check("r034_pop1", {26'd0, in_service}, 32'h10);
    check("r034_pop1_req", {31'd0, int_req}, 32'd0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    check("r034_pop2", {26'd0, in_service}, 32'h0);
`else
    check("r034_noreq", {31'd0, int_req}, 32'd0);
    check("r034_pend", {26'd0, pending}, 32'h2);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r034_ack_ignored", {26'd0, in_service}, 32'h10);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    check("r034_eret", {26'd0, in_service}, 32'h0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r034_late_cause", int_cause, 32'h0000_0800);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
`endif
    idle(2);

    // Asynchronous reset during SERVICE, with another line still pending.
    step(6'h24, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r035_cause2", int_cause, 32'h0000_1000);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    check("r035_svc", {26'd0, in_service}, 32'h4);
    check("r035_pend", {26'd0, pending}, 32'h20);
    irq = 6'h01;
    async_reset("r035");

    // irq[0] already high at release: no edge.
    step(6'h01, 1'b1, 6'h01, 1'b0, 1'b0);
    idle(5);
    check("r027_pend", {26'd0, pending}, 32'h0);
    check("r027_req", {31'd0, int_req}, 32'd0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    step(6'h01, 1'b0, 6'h00, 1'b0, 1'b0);
    check("r027_req_later", {31'd0, int_req}, 32'd1);
    step(6'h00, 1'b0, 6'h00, 1'b1, 1'b0);
    step(6'h00, 1'b0, 6'h00, 1'b0, 1'b1);
    idle(2);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] ni;
      logic [5:0] md;
      logic mw, a, e;
      ni = irq;
      for (int b = 0; b < 6; b++)
        if ($urandom_range(7) == 0) ni[b] = ~ni[b];
      mw = ($urandom_range(15) == 0);
      md = 6'($urandom);
      a  = int_req ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
      e  = ($urandom_range(3) == 0);
      step(ni, mw, md, a, e);
      if (c % 1000 == 999) async_reset("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
